scrambler_bist_ctrl: RTL

//  Self-test sequencer for the 8-bit count-down XOR scrambler datapath (clk, clear, cct_input, cct_output).
//  On start: clears the datapath, drives NUM_VECTORS LFSR stimulus bytes and compacts the returned bytes into a 16-bit MISR signature.

---
 rtl/scrambler_bist_pkg.sv | 16 +
 rtl/scrambler_bist_ctrl_if.sv | 24 ++
 rtl/scrambler_bist_misr.sv | 35 +++
 rtl/scrambler_bist_ctrl.sv | 103 ++++++++++
 4 files changed

// File: rtl/scrambler_bist_pkg.sv
// Shared types, widths and polynomial taps for the scrambler BIST sequencer.
package scrambler_bist_pkg;

   localparam int unsigned SIG_W  = 16;
   localparam int unsigned DATA_W = 8;

   localparam logic [DATA_W-1:0] LFSR_TAPS = 8'hB8;
   localparam logic [SIG_W-1:0]  MISR_TAPS = 16'h8810;

   typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} bist_state_t;

   function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] v);
      return {v[DATA_W-2:0], ^(v & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/scrambler_bist_ctrl_if.sv
// Harness-side control/status and scrambler-side drive/return signals of the BIST sequencer.
interface scrambler_bist_ctrl_if;
   import scrambler_bist_pkg::*;

   logic              start;
   logic [DATA_W-1:0] seed_in;
   logic              busy;
   logic              done;
   logic [SIG_W-1:0]  signature;
   logic              dut_clear;
   logic [DATA_W-1:0] dut_input;
   logic [DATA_W-1:0] dut_output;

   modport master (
      output start, seed_in, dut_output,
      input  busy, done, signature, dut_clear, dut_input
   );

   modport slave (
      input  start, seed_in, dut_output,
      output busy, done, signature, dut_clear, dut_input
   );

endinterface

// File: rtl/scrambler_bist_misr.sv
// 16-bit MISR compacting one returned byte per enabled cycle into the run signature.
module bist_misr16
   import scrambler_bist_pkg::*;
(
   input  logic              clk,
   input  logic              clear_n,
   input  logic              init,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   output logic [SIG_W-1:0]  sig
);

   logic [SIG_W-1:0] sig_q;
   logic [SIG_W-1:0] sig_d;

   always_comb begin
      sig_d = sig_q;
      if (init) begin
         sig_d = '0;
      end else if (en) begin
         sig_d = {sig_q[SIG_W-2:0], ^(sig_q & MISR_TAPS)} ^ {{(SIG_W-DATA_W){1'b0}}, din};
      end
   end

   always_ff @(posedge clk) begin
      if (!clear_n) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/scrambler_bist_ctrl.sv
// Self-test sequencer: clears the scrambler, drives LFSR bytes and compacts its replies.
// Optional SCRAMBLER_BIST_ABORT_EN adds an abort input that cancels a run in CLR/RUN.
module scrambler_bist_ctrl
   import scrambler_bist_pkg::*;
#(
   parameter int unsigned       NUM_VECTORS  = 256,
   parameter logic [DATA_W-1:0] SEED_DEFAULT = 8'hAA
) (
   input  logic clk,
   input  logic clear_n,
`ifdef SCRAMBLER_BIST_ABORT_EN
   input  logic abort,
`endif
   scrambler_bist_ctrl_if.slave bus
);

   localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);

   bist_state_t       state_q, state_d;
   logic [DATA_W-1:0] lfsr_q, lfsr_d;
   logic [15:0]       vec_cnt_q, vec_cnt_d;
   logic              misr_init;
   logic              misr_en;
   logic              busy;
   logic              done;
   logic              abort_w;

`ifdef SCRAMBLER_BIST_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      vec_cnt_d = vec_cnt_q;
      misr_init = 1'b0;
      misr_en   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d   = CLR;
               lfsr_d    = (bus.seed_in == '0) ? SEED_DEFAULT : bus.seed_in;
               vec_cnt_d = '0;
               misr_init = 1'b1;
            end
         end
         CLR: begin
            busy    = 1'b1;
            state_d = abort_w ? IDLE : RUN;
         end
         RUN: begin
            busy = 1'b1;
            // Abort wins over the final-vector transition and freezes the signature.
            if (abort_w) begin
               state_d = IDLE;
            end else begin
               misr_en   = 1'b1;
               lfsr_d    = lfsr_next(lfsr_q);
               vec_cnt_d = vec_cnt_q + 16'd1;
               if (vec_cnt_q == LAST_VEC) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clear_n) begin
         state_q   <= IDLE;
         lfsr_q    <= '0;
         vec_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         vec_cnt_q <= vec_cnt_d;
      end
   end

   bist_misr16 u_misr (
      .clk     (clk),
      .clear_n (clear_n),
      .init    (misr_init),
      .en      (misr_en),
      .din     (bus.dut_output),
      .sig     (bus.signature)
   );

   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.dut_clear = ~clear_n | (state_q == CLR);
   assign bus.dut_input = lfsr_q;

endmodule
